// File: rtl/xor_arb_ctrl.sv
// -----------------------------------------------------------------------------
// xor_arb_ctrl
//
// Two-requester round-robin arbiter in front of a single registered XOR unit.
// A request seen in IDLE captures the winner's operands and pulses that
// requester's grant for one cycle. The following cycle computes f = a ^ b.
// The result is then held until the consumer acknowledges it.
//
// Build option:
//   XOR_ARB_PARITY_EN  - adds output 'par', the XOR-reduction of f. It is
//                        registered together with f.
//
// Parameters:
//   WIDTH    operand / result width in bits (default 16)
//
// Ports:
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   req0/1   operation request from requester 0 / 1
//   a0, b0   operands of requester 0
//   a1, b1   operands of requester 1
//   f_ack    consumer accepts the current result
//   gnt0/1   one-cycle grant pulse; the operands have been captured
//   f        registered result; retains its value after f_valid clears
//   f_valid  f and f_id hold a valid result
//   f_id     index of the requester that owns f
//   busy     high whenever the FSM is not IDLE
//   par      (XOR_ARB_PARITY_EN only) ^f, registered with f
// -----------------------------------------------------------------------------
module xor_arb_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             f_ack,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] f,
  output logic             f_valid,
  output logic             f_id,
  output logic             busy
`ifdef XOR_ARB_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             op_id;
  // Id of the requester whose result was last acknowledged.
  // Reset to 1 so that requester 0 wins the first tie.
  logic             rr_last;

  logic             any_req;
  logic             pick1;
  logic [WIDTH-1:0] xor_res;

  always_comb begin
    any_req = req0 | req1;
    // Requester 1 wins when it is the only requester.
    // It also wins a tie when requester 0 was served last.
    pick1   = req1 & (~req0 | ~rr_last);
    xor_res = opa ^ opb;
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      opa     <= '0;
      opb     <= '0;
      op_id   <= 1'b0;
      rr_last <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      f       <= '0;
      f_valid <= 1'b0;
      f_id    <= 1'b0;
`ifdef XOR_ARB_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      // Grants are single-cycle pulses. They are re-raised only at the
      // IDLE edge that accepts a request.
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            opa   <= pick1 ? a1 : a0;
            opb   <= pick1 ? b1 : b0;
            op_id <= pick1;
            gnt0  <= ~pick1;
            gnt1  <= pick1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          f       <= xor_res;
          f_id    <= op_id;
          f_valid <= 1'b1;
`ifdef XOR_ARB_PARITY_EN
          par     <= ^xor_res;
`endif
          state   <= ST_HOLD;
        end
        ST_HOLD: begin
          // The round-robin pointer advances only on acknowledge.
          // An abandoned operation therefore never shifts priority.
          if (f_ack) begin
            f_valid <= 1'b0;
            rr_last <= f_id;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_arb_ctrl.sv
module tb_xor_arb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        f_ack;
  logic        gnt0, gnt1;
  logic [15:0] f;
  logic        f_valid;
  logic        f_id;
  logic        busy;
`ifdef XOR_ARB_PARITY_EN
  logic        par;
`endif

  xor_arb_ctrl #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .f_ack   (f_ack),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .f       (f),
    .f_valid (f_valid),
    .f_id    (f_id),
    .busy    (busy)
`ifdef XOR_ARB_PARITY_EN
    ,
    .par     (par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          r0;
    bit          r1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [15:0] a1;
    logic [15:0] b1;
    bit          exp_id;
    logic [15:0] exp_f;
  } vec_t;

  typedef struct {
    logic [15:0] f;
    logic        id;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive a request at a negedge and wait, bounded, for a grant.
  // The grant must be visible one edge later.
  task automatic issue(input bit r0, input bit r1, input logic [15:0] x0, input logic [15:0] y0,
                       input logic [15:0] x1, input logic [15:0] y1,
                       input bit exp_id, input logic [15:0] exp_f);
    int n;
    exp_t e;
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
    end while (!(gnt0 | gnt1) && n < 8);
    check("gnt_latency", n, 1);
    check("gnt_id", {31'd0, gnt1}, {31'd0, exp_id});
    check("gnt_excl", {31'd0, gnt0 & gnt1}, 0);
    e.f = exp_f; e.id = exp_id;
    sb.push_back(e);
    req0 = 1'b0; req1 = 1'b0;
    a0 = 16'hdead; b0 = 16'hbeef; a1 = 16'hc0de; b1 = 16'hf00d;
  endtask

  // Wait, bounded, for f_valid, then compare the result against the scoreboard.
  task automatic collect(output logic [15:0] got_f);
    int n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk); @(negedge clk); n++;
      check("gnt_pulse_off", {30'd0, gnt0, gnt1}, 0);
    end while (!f_valid && n < 8);
    check("valid_latency", n, 1);
    got_f = f;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("f", {16'd0, f}, {16'd0, e.f});
      check("f_id", {31'd0, f_id}, {31'd0, e.id});
`ifdef XOR_ARB_PARITY_EN
      check("par", {31'd0, par}, {31'd0, ^e.f});
`endif
    end
  endtask

  task automatic ack(input logic [15:0] exp_f);
    f_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    f_ack = 1'b0;
    check("valid_clr", {31'd0, f_valid}, 0);
    check("busy_clr", {31'd0, busy}, 0);
    check("f_retain", {16'd0, f}, {16'd0, exp_f});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] gf;
    int          n;
    bit          saw;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'haaaa, 16'h00ff, 16'h0000, 16'h0000, 1'b0, 16'haa55};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'h0f0f, 16'h3333, 16'hffff, 16'h0001, 1'b0, 16'h3c3c};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0f0f, 16'h3333, 16'hffff, 16'h0001, 1'b1, 16'hfffe};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0f0f, 16'h3333, 16'hffff, 16'h0001, 1'b0, 16'h3c3c};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 1'b1, 16'h8000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'hffff, 16'h0000, 16'h0000, 1'b0, 16'hedcb};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h5555, 16'h5555, 16'h0001, 16'h0003, 1'b1, 16'h0002};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 16'hffff, 16'hffff, 16'h7fff, 16'hffff, 1'b1, 16'h8000};

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; f_ack = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    #1;
    check("rst_gnt", {30'd0, gnt0, gnt1}, 0);
    check("rst_f", {16'd0, f}, 0);
    check("rst_valid_id_busy", {29'd0, f_valid, f_id, busy}, 0);
`ifdef XOR_ARB_PARITY_EN
    check("rst_par", {31'd0, par}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Ack while idle with no requests is ignored.
    f_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check("idle_ack_valid", {31'd0, f_valid}, 0);
      check("idle_ack_busy", {31'd0, busy}, 0);
    end
    f_ack = 1'b0;

    // A request withdrawn before the edge that would sample it has no effect.
    req0 = 1'b1;
    #2 req0 = 1'b0;
    @(posedge clk); @(negedge clk);
    check("withdraw_gnt", {30'd0, gnt0, gnt1}, 0);
    check("withdraw_busy", {31'd0, busy}, 0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rst) do_reset();
      issue(vecs[i].r0, vecs[i].r1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
            vecs[i].exp_id, vecs[i].exp_f);
      collect(gf);
      ack(vecs[i].exp_f);
    end

    // Result held while ack stays low and req1 toggles; no grant until ack.
    issue(1'b1, 1'b0, 16'h00f0, 16'h0f00, 16'h0, 16'h0, 1'b0, 16'h0ff0);
    collect(gf);
    a1 = 16'h1111; b1 = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      req1 = ~req1;
      @(posedge clk); @(negedge clk);
      check("hold_f", {16'd0, f}, 32'h0ff0);
      check("hold_valid", {31'd0, f_valid}, 1);
      check("hold_gnt1", {31'd0, gnt1}, 0);
    end
    req1 = 1'b1;
    ack(16'h0ff0);
    check("ack_edge_gnt1", {31'd0, gnt1}, 0);
    issue(1'b0, 1'b1, 16'h0, 16'h0, 16'h1111, 16'h2222, 1'b1, 16'h3333);
    collect(gf);
    ack(16'h3333);

    // Asynchronous reset during EXEC abandons the operation.
    issue(1'b1, 1'b0, 16'h00ff, 16'h0f0f, 16'h0, 16'h0, 1'b0, 16'h0ff0);
    check("exec_busy", {31'd0, busy}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_gnt", {30'd0, gnt0, gnt1}, 0);
    check("async_f", {16'd0, f}, 0);
    check("async_valid_id_busy", {29'd0, f_valid, f_id, busy}, 0);
`ifdef XOR_ARB_PARITY_EN
    check("async_par", {31'd0, par}, 0);
`endif
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (f_valid || busy) saw = 1'b1;
    end
    check("no_result_after_rst", {31'd0, saw}, 0);

    // Fresh reset restores requester-0 priority.
    n = 0;
    issue(1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 1'b0, 16'h0003);
    collect(gf);
    ack(16'h0003);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
